ssd_scanner: RTL and testbench

//  Time-multiplexes a 16-bit value onto a 4-digit common-anode 7-segment display.

---
 rtl/ssd_scanner.sv | 127 ++++++++++++
 tb/tb_ssd_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scanner.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned shadow commit; all outputs registered, load is never stalled.
// Optional leading-zero blanking is enabled by defining SSD_BLANK_EN.
module ssd_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  output logic [3:0]            nibble_out,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_digit_idx;
  logic                  r_drive;
  logic [4*DIGITS-1:0]   r_display;
  logic [4*DIGITS-1:0]   r_shadow;
  logic                  r_pending;
  logic [DIGITS-1:0]     r_anode_n;
  logic [3:0]            r_nibble;
  logic                  r_frame_tick;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_frame;
  logic [3:0]            w_nib;
  logic [DIGITS-1:0]     w_sel;
  logic [DIGITS-1:0]     w_nz_above;
  logic [DIGITS-1:0]     w_anode_drv;

  assign w_tick  = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_last  = (r_digit_idx == IW'(DIGITS - 1));
  assign w_frame = w_tick & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // r_drive marks the cycle after a tick, when the new slot's digit is lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit_idx  <= IW'(DIGITS - 1);
      r_drive      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_drive      <= w_tick;
      r_frame_tick <= w_frame;
      if (w_tick) begin
        r_digit_idx <= w_last ? '0 : r_digit_idx + IW'(1);
      end
    end
  end

  // A load on the commit edge still lands in the shadow and stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_frame && r_pending) begin
        r_display <= r_shadow;
      end
      if (load) begin
        r_shadow  <= value_in;
        r_pending <= 1'b1;
      end else if (w_frame) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    logic v_acc;
    w_nib      = '0;
    w_nz_above = '0;
    v_acc      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_digit_idx == IW'(i)) begin
        w_nib = r_display[4*i +: 4];
      end
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_acc         = v_acc | (|r_display[4*i +: 4]);
      w_nz_above[i] = v_acc;
    end
  end

  assign w_sel = DIGITS'(1) << r_digit_idx;

`ifdef SSD_BLANK_EN
  assign w_anode_drv = ~(w_sel & (w_nz_above | DIGITS'(1)));
`else
  assign w_anode_drv = ~w_sel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anode_n <= '1;
      r_nibble  <= '0;
    end else if (w_tick) begin
      r_anode_n <= '1;
    end else if (r_drive) begin
      r_anode_n <= w_anode_drv;
      r_nibble  <= w_nib;
    end
  end

  assign nibble_out = r_nibble;
  assign anode_n    = r_anode_n;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

// File: tb/tb_ssd_scanner.sv
// Randomized bench for ssd_scanner against an edge-count based reference model.
module tb_ssd_scanner;

  localparam int R = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic [3:0]  nibble_out;
  logic [3:0]  anode_n;
  logic        frame_tick;
  logic        pending;

  ssd_scanner #(.REFRESH_DIV(R), .DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
    .nibble_out(nibble_out), .anode_n(anode_n), .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: n = rising edges since reset release; slot k starts at edge k*R.
  int          n;
  logic [15:0] m_shadow, m_display;
  logic        m_pending, m_ft;
  logic [3:0]  m_anode, m_nib;

  task automatic model_reset();
    n = 0; m_shadow = '0; m_display = '0; m_pending = 1'b0;
    m_ft = 1'b0; m_anode = 4'hF; m_nib = 4'h0;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] v);
    int k, dg;
    n++;
    m_ft = 1'b0;
    k = n / R;
    if (n % R == 0) begin
      m_anode = 4'hF;
      if ((k - 1) % D == 0) begin
        m_ft = 1'b1;
        if (m_pending) begin
          m_display = m_shadow;
          m_pending = 1'b0;
        end
      end
    end else if (n % R == 1 && n > R) begin
      dg      = (k - 1) % D;
      m_nib   = 4'((m_display >> (4 * dg)) & 16'hF);
      m_anode = ~(4'b0001 << dg);
`ifdef SSD_BLANK_EN
      if (dg > 0 && (m_display >> (4 * dg)) == 16'h0) m_anode = 4'hF;
`endif
    end
    if (ld) begin
      m_shadow  = v;
      m_pending = 1'b1;
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] v);
    load = ld; value_in = v;
    @(posedge clk);
    model_edge(ld, v);
    #1;
    load = 1'b0;
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({anode_n, nibble_out, frame_tick, pending} !== {4'hF, 4'h0, 1'b0, 1'b0})
      $display("FAIL reset_async got an=%b nib=%h ft=%b pd=%b exp an=1111 nib=0 ft=0 pd=0",
               anode_n, nibble_out, frame_tick, pending);
    else n_pass++;
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 16'h9876);
    for (int i = 0; i < 14; i++) step(1'b0, 16'h0);
    apply_reset();
    for (int i = 0; i < 2 * R * D; i++) begin
      step(1'b0, 16'($urandom));
      n_checks++;
      if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
        $display("FAIL reset_after n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                 n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    apply_reset();
    step(1'b1, 16'h1234);
    for (int i = 0; i < 3 * R * D; i++) begin
      step(1'b0, 16'h0);
      n_checks++;
      if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
        $display("FAIL scan n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                 n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
      else n_pass++;
    end
  endtask

  task automatic test_mid_frame_load();
    for (int i = 0; i < R * D + 2; i++) begin
      if (n % R == 2 && ((n / R) - 1) % D == 1) break;
      step(1'b0, 16'h0);
    end
    step(1'b1, 16'hABCD);
    for (int i = 0; i < 2 * R * D; i++) begin
      step(1'b0, 16'h0);
      n_checks++;
      if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
        $display("FAIL mid_frame_load n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                 n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
      else n_pass++;
    end
  endtask

  task automatic test_double_load();
    for (int i = 0; i < R * D + 2; i++) begin
      if (n % (R * D) == R + 1) break;
      step(1'b0, 16'h0);
    end
    step(1'b1, 16'h1111);
    step(1'b0, 16'h0);
    step(1'b1, 16'h2222);
    for (int i = 0; i < 2 * R * D; i++) begin
      step(1'b0, 16'h3333);
      n_checks++;
      if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
        $display("FAIL double_load n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                 n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
      else n_pass++;
    end
  endtask

  task automatic test_load_on_commit();
    step(1'b1, 16'h1234);
    for (int i = 0; i < 2 * R * D + 2; i++) begin
      if ((n + 1) % (R * D) == R && m_display == 16'h1234) break;
      step(1'b0, 16'h0);
    end
    step(1'b1, 16'h5678);
    for (int i = 0; i < 3 * R * D; i++) begin
      step(1'b0, 16'h0);
      n_checks++;
      if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
        $display("FAIL load_on_commit n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                 n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
      else n_pass++;
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] vals [3];
    vals[0] = 16'h0050; vals[1] = 16'h0000; vals[2] = 16'h0700;
    for (int v = 0; v < 3; v++) begin
      step(1'b1, vals[v]);
      for (int i = 0; i < 2 * R * D + 2; i++) begin
        step(1'b0, 16'h0);
        n_checks++;
        if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
          $display("FAIL leading_zeros val=%h n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                   vals[v], n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic        ld;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      ld = ($urandom_range(0, 5) == 0);
      step(ld, v);
      n_checks++;
      if ({anode_n, nibble_out, frame_tick, pending} !== {m_anode, m_nib, m_ft, m_pending})
        $display("FAIL random n=%0d got an=%b nib=%h ft=%b pd=%b exp an=%b nib=%h ft=%b pd=%b",
                 n, anode_n, nibble_out, frame_tick, pending, m_anode, m_nib, m_ft, m_pending);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_frame_load();
    test_double_load();
    test_load_on_commit();
    test_leading_zeros();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
